// File: rtl/alu_cdb_stage.sv
// ALU result FIFO and CDB broadcast stage with JAL/JALR redirect.
// Define ALU_CDB_BYPASS_EN to let results skip an empty FIFO when a grant is already present.
module alu_cdb_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned RSNUM_W = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alu_valid,
  input  logic [RSNUM_W-1:0] alu_rsnum,
  input  logic [TAG_W-1:0]   alu_tag,
  input  logic [DATA_W-1:0]  alu_data,
  input  logic [ADDR_W-1:0]  alu_offset,
  input  logic               alu_pc_valid,
  output logic               alu_ready,
  output logic               cdb_req,
  input  logic               cdb_grant,
  output logic               cdb_valid,
  output logic [RSNUM_W-1:0] cdb_rsnum,
  output logic [TAG_W-1:0]   cdb_tag,
  output logic [DATA_W-1:0]  cdb_data,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  logic [RSNUM_W-1:0] rsnum_mem  [DEPTH];
  logic [TAG_W-1:0]   tag_mem    [DEPTH];
  logic [DATA_W-1:0]  data_mem   [DEPTH];
  logic [ADDR_W-1:0]  offset_mem [DEPTH];
  logic               pcv_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               valid_q, valid_d;
  logic [RSNUM_W-1:0] rsnum_q, rsnum_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               redir_q, redir_d;
  logic [ADDR_W-1:0]  redir_pc_q, redir_pc_d;

  logic tag_ok, empty, push, pop, bypass;

  // Tag 0 is tagFree: such results never enter the FIFO or the bus.
  assign tag_ok    = alu_valid && (alu_tag != '0);
  assign empty     = (count_q == '0);
  assign alu_ready = (count_q != CntFull);

`ifdef ALU_CDB_BYPASS_EN
  assign bypass  = empty && tag_ok && cdb_grant;
  assign cdb_req = !empty || tag_ok;
`else
  assign bypass  = 1'b0;
  assign cdb_req = !empty;
`endif

  // Queued entries always win the grant over a bypass.
  assign pop  = cdb_req && cdb_grant && !empty;
  assign push = tag_ok && alu_ready && !bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    valid_d    = 1'b0;
    rsnum_d    = '0;
    tag_d      = '0;
    data_d     = '0;
    redir_d    = 1'b0;
    redir_pc_d = '0;
    if (pop) begin
      valid_d    = 1'b1;
      rsnum_d    = rsnum_mem[rd_ptr_q];
      tag_d      = tag_mem[rd_ptr_q];
      data_d     = data_mem[rd_ptr_q];
      redir_d    = pcv_mem[rd_ptr_q];
      redir_pc_d = pcv_mem[rd_ptr_q] ? offset_mem[rd_ptr_q] : '0;
    end else if (bypass) begin
      valid_d    = 1'b1;
      rsnum_d    = alu_rsnum;
      tag_d      = alu_tag;
      data_d     = alu_data;
      redir_d    = alu_pc_valid;
      redir_pc_d = alu_pc_valid ? alu_offset : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      rsnum_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      rsnum_q    <= rsnum_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (rst && !flush && push) begin
      rsnum_mem[wr_ptr_q]  <= alu_rsnum;
      tag_mem[wr_ptr_q]    <= alu_tag;
      data_mem[wr_ptr_q]   <= alu_data;
      offset_mem[wr_ptr_q] <= alu_offset;
      pcv_mem[wr_ptr_q]    <= alu_pc_valid;
    end
  end

  assign cdb_valid      = valid_q;
  assign cdb_rsnum      = rsnum_q;
  assign cdb_tag        = tag_q;
  assign cdb_data       = data_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_alu_cdb_stage.sv
// Bench for alu_cdb_stage: queue-based reference model checked every cycle plus directed vectors.
module tb_alu_cdb_stage;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned RSNUM_W = 2;
  localparam int unsigned DEPTH   = 4;

`ifdef ALU_CDB_BYPASS_EN
  localparam int ExpLat = 1;
`else
  localparam int ExpLat = 2;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic               alu_valid = 1'b0;
  logic [RSNUM_W-1:0] alu_rsnum = '0;
  logic [TAG_W-1:0]   alu_tag = '0;
  logic [DATA_W-1:0]  alu_data = '0;
  logic [ADDR_W-1:0]  alu_offset = '0;
  logic               alu_pc_valid = 1'b0;
  logic               cdb_grant = 1'b0;
  logic               alu_ready, cdb_req, cdb_valid, redirect_valid;
  logic [RSNUM_W-1:0] cdb_rsnum;
  logic [TAG_W-1:0]   cdb_tag;
  logic [DATA_W-1:0]  cdb_data;
  logic [ADDR_W-1:0]  redirect_pc;

  alu_cdb_stage #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TAG_W   (TAG_W),
    .RSNUM_W (RSNUM_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alu_valid      (alu_valid),
    .alu_rsnum      (alu_rsnum),
    .alu_tag        (alu_tag),
    .alu_data       (alu_data),
    .alu_offset     (alu_offset),
    .alu_pc_valid   (alu_pc_valid),
    .alu_ready      (alu_ready),
    .cdb_req        (cdb_req),
    .cdb_grant      (cdb_grant),
    .cdb_valid      (cdb_valid),
    .cdb_rsnum      (cdb_rsnum),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RSNUM_W-1:0] rsnum;
    logic [TAG_W-1:0]   tag;
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  off;
    logic               pcv;
  } ent_t;

  ent_t mq[$];
  ent_t mo;
  logic mo_valid = 1'b0;
  bit   check_en = 1'b0;
  bit   exp_req;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic ent_t zero_ent();
    ent_t e;
    e.rsnum = '0; e.tag = '0; e.data = '0; e.off = '0; e.pcv = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of results, updated from the inputs seen at each edge.
  task automatic model_step();
    int   n;
    bit   byp, pop, push;
    ent_t e;
    n = mq.size();
    if (!rst || flush) begin
      mq.delete();
      mo_valid = 1'b0;
      mo = zero_ent();
    end else begin
      byp = 1'b0;
`ifdef ALU_CDB_BYPASS_EN
      byp = (n == 0) && alu_valid && (alu_tag != 0) && cdb_grant;
`endif
      pop  = (n != 0) && cdb_grant;
      push = alu_valid && (alu_tag != 0) && (n != DEPTH) && !byp;
      e.rsnum = alu_rsnum; e.tag = alu_tag; e.data = alu_data;
      e.off = alu_offset; e.pcv = alu_pc_valid;
      if (pop) begin
        mo_valid = 1'b1;
        mo = mq.pop_front();
      end else if (byp) begin
        mo_valid = 1'b1;
        mo = e;
      end else begin
        mo_valid = 1'b0;
        mo = zero_ent();
      end
      if (!mo.pcv) mo.off = '0;
      if (push) mq.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      exp_req = (mq.size() != 0);
`ifdef ALU_CDB_BYPASS_EN
      exp_req = exp_req || (alu_valid && (alu_tag != 0));
`endif
      chk("model alu_ready", alu_ready, mq.size() != DEPTH);
      chk("model cdb_req", cdb_req, exp_req);
      chk("model cdb_valid", cdb_valid, mo_valid);
      chk("model cdb_rsnum", cdb_rsnum, mo.rsnum);
      chk("model cdb_tag", cdb_tag, mo.tag);
      chk("model cdb_data", cdb_data, mo.data);
      chk("model redirect_valid", redirect_valid, mo.pcv);
      chk("model redirect_pc", redirect_pc, mo.off);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int rs, input int tg, input int d, input int off, input bit pcv);
    alu_valid    = 1'b1;
    alu_rsnum    = RSNUM_W'(rs);
    alu_tag      = TAG_W'(tg);
    alu_data     = DATA_W'(d);
    alu_offset   = ADDR_W'(off);
    alu_pc_valid = pcv;
  endtask

  task automatic idle();
    alu_valid    = 1'b0;
    alu_rsnum    = '0;
    alu_tag      = '0;
    alu_data     = '0;
    alu_offset   = '0;
    alu_pc_valid = 1'b0;
  endtask

  // Drive one result with grant held and return edges until cdb_valid plus the broadcast fields.
  task automatic send_and_wait(input int rs, input int tg, input int d, input int off,
                               input bit pcv, output int lat, output ent_t got, output bit rv);
    lat = 0;
    got = zero_ent();
    rv = 1'b0;
    cdb_grant = 1'b1;
    send(rs, tg, d, off, pcv);
    for (int i = 1; i <= 10; i++) begin
      tick();
      idle();
      if (cdb_valid) begin
        lat = i;
        got.rsnum = cdb_rsnum; got.tag = cdb_tag; got.data = cdb_data;
        got.off = redirect_pc; rv = redirect_valid;
        break;
      end
    end
  endtask

  int            lat;
  ent_t          got_e;
  bit            got_rv;
  logic [3:0]    got[$];
  int            seen;

  initial begin
    // Reset
    rst = 1'b0;
    tick();
    check_en = 1'b1;
    tick();
    chk("reset cdb_valid", cdb_valid, 0);
    chk("reset cdb_tag", cdb_tag, 0);
    chk("reset redirect_valid", redirect_valid, 0);
    chk("reset alu_ready", alu_ready, 1);
    chk("reset cdb_req", cdb_req, 0);
    rst = 1'b1;
    tick();

    // Single result
    send_and_wait(1, 3, 'h1234, 0, 1'b0, lat, got_e, got_rv);
    chk("single latency", lat, ExpLat);
    chk("single tag", got_e.tag, 3);
    chk("single data", got_e.data, 'h1234);
    chk("single rsnum", got_e.rsnum, 1);
    tick();
    chk("single width", cdb_valid, 0);
    cdb_grant = 1'b0;
    tick();

    // Fill to full, fifth push lost, then drain in order
    for (int i = 1; i <= 5; i++) begin
      send(i % 4, i, i * 'h11, 0, 1'b0);
      tick();
      if (i == 3) chk("full ready after 3", alu_ready, 1);
      if (i == 4) chk("full ready after 4", alu_ready, 0);
    end
    idle();
    cdb_grant = 1'b1;
    got.delete();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (cdb_valid) got.push_back(cdb_tag);
    end
    chk("full drain count", got.size(), 4);
    for (int k = 0; k < got.size() && k < 4; k++) chk("full drain order", got[k], k + 1);
    chk("full drained req", cdb_req, 0);
    cdb_grant = 1'b0;
    tick();

    // Jump result
    send_and_wait(2, 6, 'h88, 'h100, 1'b1, lat, got_e, got_rv);
    chk("jump redirect_valid", got_rv, 1);
    chk("jump redirect_pc", got_e.off, 'h100);
    chk("jump data", got_e.data, 'h88);
    cdb_grant = 1'b0;
    tick();

    // Flush with simultaneous push and grant
    for (int i = 7; i <= 9; i++) begin
      send(0, i, i, 0, 1'b0);
      tick();
    end
    flush = 1'b1;
    cdb_grant = 1'b1;
    send(3, 10, 'hAA, 0, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    chk("flush cdb_valid", cdb_valid, 0);
    chk("flush cdb_req", cdb_req, 0);
    chk("flush alu_ready", alu_ready, 1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cdb_valid) seen++;
    end
    chk("flush no broadcast", seen, 0);

    // Tag 0 results are dropped
    send(1, 0, 'h55, 0, 1'b0);
    tick();
    idle();
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (cdb_valid) seen++;
      tick();
    end
    chk("tag0 dropped", seen, 0);
    chk("tag0 req", cdb_req, 0);

    // Back-to-back push and pop across pointer wrap
    got.delete();
    for (int i = 1; i <= 10; i++) begin
      send(i % 4, i, i * 16, 0, 1'b0);
      tick();
      if (cdb_valid) got.push_back(cdb_tag);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cdb_valid) got.push_back(cdb_tag);
    end
    chk("wrap count", got.size(), 10);
    for (int k = 0; k < got.size() && k < 10; k++) chk("wrap order", got[k], k + 1);
    cdb_grant = 1'b0;
    tick();

    // Reset mid-operation discards entries
    send(0, 1, 1, 0, 1'b0);
    tick();
    send(0, 2, 2, 0, 1'b0);
    tick();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midreset cdb_req", cdb_req, 0);
    chk("midreset alu_ready", alu_ready, 1);
    cdb_grant = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cdb_valid) seen++;
    end
    chk("midreset no broadcast", seen, 0);
    cdb_grant = 1'b0;
    tick();
    tick();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
